muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit that sits directly upstream of the register-file write port. It accepts one M-extension operation with its operand values and destination index, and computes the result over a fixed number of cycles. It then presents a single-cycle write-back (`wb_valid`/`wb_rd`/`wb_data`) that drives the register file's `write_enable`/`rd`/`rd_din`. The control path holds the issuing instruction while `busy` is high.

## Interface
- `XLEN`, default 32: operand/result width. The iteration count equals `XLEN`; only 32 is required to be supported.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: request to begin an operation. Sampled only when `busy`=0.
- `funct3` input 3: operation. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val` input XLEN: operand A (multiplicand / dividend).
- `rs2_val` input XLEN: operand B (multiplier / divisor).
- `rd_in` input 5: destination register index.
- `busy` output 1: high from the cycle after acceptance through the DONE cycle.
- `wb_valid` output 1: one-cycle write-back strobe.
- `wb_rd` output 5: destination index; valid while `wb_valid`=1.
- `wb_data` output XLEN: result; valid while `wb_valid`=1.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: when `start`=1, latch `funct3`, `rd_in`, and operand magnitudes plus sign flags, clear the counter, and go to RUN.
  - RUN: performs one iteration per cycle (shift-add for multiply, restoring shift-subtract for divide). Leaves for DONE after exactly XLEN iterations.
  - DONE: drives results and returns to IDLE on the next edge.
- Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Signed operands are converted to magnitudes. The final result is negated when the sign flags require it:
  - Product: negate if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
- Result selection:
  - MUL returns the low XLEN bits of the 2·XLEN-bit product.
  - MULH, MULHSU, MULHU return the high XLEN bits.
- Divide by zero (checked at acceptance):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = `rs1_val`.
  - Latency is unchanged.
- Signed overflow (`rs1`=0x80000000, `rs2`=0xFFFFFFFF):
  - DIV = 0x80000000.
  - REM = 0.
  - Latency is unchanged.
- `rd_in`=0: the operation runs normally, but `wb_valid` stays 0 in DONE. x0 is never written.
- `start` while `busy`=1 (including the DONE cycle) is ignored. Nothing is queued.
- Operand inputs need not be held after the accepting edge.

## Timing
- Cycle 0 is the cycle in which `start`=1 and `busy`=0 are sampled.
- Cycles 1..XLEN: RUN, with `busy`=1.
- Cycle XLEN+1: DONE, with `busy`=1, `wb_valid`=1 (if `rd`≠0), and `wb_rd`/`wb_data` valid. The register file writes on the edge that ends this cycle.
- Cycle XLEN+2: IDLE with `busy`=0. A new `start` can be accepted in this cycle, giving a throughput of one operation per XLEN+2 cycles.
- Outputs are registered. `wb_valid` is never high for more than one consecutive cycle.
- Reset values: FSM = IDLE, counter = 0, `busy`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
- Reset asserted mid-operation (RUN or DONE): the FSM returns to IDLE on that edge. No `wb_valid` is produced for the aborted operation. If `reset` and `start` are both high, reset wins.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined: MUL/MULH/MULHSU/MULHU use a single combinational 2·XLEN-bit multiplier. IDLE goes directly to DONE, so `wb_valid` occurs in cycle 1 and `busy`=1 only in cycle 1. Divides are unchanged at XLEN+1 cycles.
  - Undefined: all eight operations use the iterative path with latency XLEN+1.

## Test plan
- MUL with `rs1`=7, `rs2`=0xFFFFFFFD (−3), `rd`=5 → `wb_valid` in cycle 33 (cycle 1 with the macro), `wb_rd`=5, `wb_data`=0xFFFFFFEB. `busy` falls in cycle 34.
- MULH with 0x80000000 × 0x80000000 → 0x40000000. MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU with 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0. REM −7 % 2 → 0xFFFFFFFF. DIV −7 / 2 → 0xFFFFFFFD.
- DIVU 0x1234 / 0 → 0xFFFFFFFF. REMU 0x1234 / 0 → 0x1234. Both have a latency of 33 cycles.
- Start a DIV, pulse `start` again in cycle 5 with different operands, then assert `reset` in a second run at cycle 10 → the first result is unaffected by the cycle-5 pulse. After the reset edge: `busy`=0, and no `wb_valid` appears for 40 cycles.
- MUL with `rd_in`=0 → `busy` runs for cycles 1..33, `wb_valid` stays 0 throughout, and a back-to-back `start` in cycle 34 is accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Multiplies use shift-add, divides use restoring shift-subtract, XLEN
// iterations each. Define MULDIV_FAST_MUL_EN to route the four multiplies
// through a single-cycle combinational multiplier instead.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;          // negate product / quotient
  logic            neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic            div0_q, div0_d;
  logic [XLEN-1:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;            // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;            // multiplier->product low / dividend->quotient
  logic            busy_q, busy_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Apply sign fix-ups to raw magnitude results and pick the requested word.
  function automatic logic [XLEN-1:0] finish_f(input logic [2:0]      op,
                                               input logic            neg,
                                               input logic            neg_rem,
                                               input logic            div0,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r, res;
    p = neg ? ('0 - {hi, lo}) : {hi, lo};
    q = div0 ? '1 : (neg ? ('0 - lo) : lo);
    r = neg_rem ? ('0 - hi) : hi;
    case (op)
      3'b000:                 res = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = q;
      default:                res = r;
    endcase
    return res;
  endfunction

  // Operand signedness from funct3 and conversion to magnitudes.
  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    sign_a   = signed_a & rs1_val[XLEN-1];
    sign_b   = signed_b & rs2_val[XLEN-1];
    mag_a    = sign_a ? ('0 - rs1_val) : rs1_val;
    mag_b    = sign_b ? ('0 - rs2_val) : rs2_val;
  end

  // One multiply or divide iteration on the working registers.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // FSM next state, operand capture and registered write-back generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod  = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = funct3;
          rd_d      = rd_in;
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = (rs2_val == '0);
          cnt_d     = '0;
          hi_d      = '0;
          if (funct3[2]) begin
            mcand_d = mag_b;
            lo_d    = mag_a;
          end else begin
            mcand_d = mag_a;
            lo_d    = mag_b;
          end
          state_d = StRun;
`ifdef MULDIV_FAST_MUL_EN
          if (!funct3[2]) begin
            fast_prod  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
            state_d    = StDone;
            wb_valid_d = (rd_in != '0);
            wb_rd_d    = rd_in;
            wb_data_d  = finish_f(funct3, sign_a ^ sign_b, sign_a, 1'b0,
                                  fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
          end
`endif
        end
      end
      StRun: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d    = StDone;
          wb_valid_d = (rd_q != '0);
          wb_rd_d    = rd_q;
          wb_data_d  = finish_f(op_q, neg_q, neg_rem_q, div0_q, step_hi, step_lo);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign busy     = busy_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit with an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .rd_in    (rd_in),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain 64-bit / int arithmetic.
  function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'($signed(a));
    ib = int'($signed(b));
    p = 0;
    r = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(ia / ib);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (FastMul && !op[2]) ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one start pulse (caller is just after an edge); leaves us in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    funct3  = op;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
  endtask

  // Observe until wb_valid or a cycle budget runs out; no checking here.
  task automatic wait_wb(input int cyc0, output bit seen, output int lat, output bit busy_ok,
                         output logic [4:0] rd, output logic [31:0] data);
    int cyc;
    cyc = cyc0;
    seen = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    rd = '0;
    data = '0;
    while (!seen && cyc < cyc0 + 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (wb_valid === 1'b1) begin
        seen = 1'b1;
        lat  = cyc;
        rd   = wb_rd;
        data = wb_data;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b1;
    funct3  = 3'd4;
    rs1_val = 32'd100;
    rs2_val = 32'd3;
    rd_in   = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %h expected 00", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h expected 00000000", wb_data); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    vec_t v[$];
    bit seen, busy_ok;
    int lat;
    logic [4:0] rd;
    logic [31:0] data;
    v.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB});
    v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000});
    v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE});
    v.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF});
    v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000});
    v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0});
    v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF});
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD});
    v.push_back('{3'd5, 32'h1234, 32'd0, 5'd13, 32'hFFFF_FFFF});
    v.push_back('{3'd7, 32'h1234, 32'd0, 5'd14, 32'h1234});
    v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 5'd31, 32'hFFFF_FFFF});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      wait_wb(1, seen, lat, busy_ok, rd, data);
      checks++; if (lat != exp_lat(v[i].op)) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(v[i].op)); end
      checks++; if (data !== v[i].exp) begin errors++; $display("FAIL dir%0d_data: got %h expected %h", i, data, v[i].exp); end
      checks++; if (rd !== v[i].rd) begin errors++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rd, v[i].rd); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL dir%0d_busy_run: got 0 expected 1 during operation", i); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_after_done: busy/wb_valid got %b%b expected 00", i, busy, wb_valid); end
    end
  endtask

  task automatic test_random();
    bit seen, busy_ok;
    int lat;
    logic [4:0] rd, rdx;
    logic [31:0] data, a, b, exp;
    logic [2:0] op;
    for (int n = 0; n < 60; n++) begin
      op  = 3'($urandom_range(7));
      a   = pick();
      b   = pick();
      rdx = 5'($urandom_range(31, 1));
      exp = ref_f(op, a, b);
      issue(op, a, b, rdx);
      wait_wb(1, seen, lat, busy_ok, rd, data);
      checks++; if (data !== exp || rd !== rdx) begin errors++; $display("FAIL rand%0d_op%0d: got rd %0d data %h expected rd %0d data %h (a=%h b=%h)", n, op, rd, data, rdx, exp, a, b); end
      checks++; if (lat != exp_lat(op)) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, exp_lat(op)); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_and_abort();
    bit seen, busy_ok, bad;
    int lat;
    logic [4:0] rd;
    logic [31:0] data;
    issue(3'd4, 32'd100, 32'd7, 5'd3);
    repeat (4) begin @(posedge clk); #1; end
    funct3  = 3'd5;
    rs1_val = 32'd1000;
    rs2_val = 32'd9;
    rd_in   = 5'd9;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_wb(6, seen, lat, busy_ok, rd, data);
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    checks++; if (data !== 32'd14 || rd !== 5'd3) begin errors++; $display("FAIL ignore_result: got rd %0d data %h expected rd 3 data 0000000e", rd, data); end
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || wb_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL ignore_no_queue: got activity expected idle"); end

    issue(3'd4, 32'd5000, 32'd3, 5'd17);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin errors++; $display("FAIL abort_outputs: got %b/%0d/%h expected 0/0/00000000", wb_valid, wb_rd, wb_data); end
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (wb_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_wb: got wb_valid=1 expected none for 40 cycles"); end
  endtask

  task automatic test_rd_zero_back_to_back();
    bit seen, busy_ok, bad_busy, bad_wb;
    int lat, len;
    logic [4:0] rd;
    logic [31:0] data;
    len = exp_lat(3'd0);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd0);
    bad_busy = 1'b0;
    bad_wb   = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (busy !== 1'b1) bad_busy = 1'b1;
      if (wb_valid !== 1'b0) bad_wb = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (bad_busy) begin errors++; $display("FAIL rd0_busy: got a low cycle expected busy in cycles 1..%0d", len); end
    checks++; if (bad_wb || wb_valid !== 1'b0) begin errors++; $display("FAIL rd0_wb_valid: got a strobe expected none"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd0_busy_fall: got %b expected 0 in cycle %0d", busy, len + 1); end
    issue(3'd0, 32'd3, 32'd5, 5'd21);
    wait_wb(1, seen, lat, busy_ok, rd, data);
    checks++; if (lat != len || data !== 32'd15 || rd !== 5'd21) begin errors++; $display("FAIL b2b_result: got lat %0d rd %0d data %h expected lat %0d rd 21 data 0000000f", lat, rd, data, len); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_and_abort();
    test_rd_zero_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
